handshake_tx: RTL
=================

// Module: handshake_tx
// PURPOSE
//  Transmit (source) end of the valid/ready handshake: buffers words loaded by local logic and
//  presents them one at a time on valid/data_out to a downstream receiver. Holds data stable
//  until the receiver accepts it. Flags overflow and receiver stalls.
//  Sits between a local producer (e.g. the data_in counter) and the handshake receiver.
// PARAMETERS
//  DW       4    data width, bits
//  DEPTH    4    buffer entries; power of 2, >=2; AW = $clog2(DEPTH)
//  TIMEOUT  16   cycles of valid&&!ready that raise stall; 0 = stall detection off
// PORTS
//  clk        in   1       clock; all logic on posedge
//  rst_n      in   1       synchronous reset, active low
//  load       in   1       push load_data into buffer this edge
//  load_data  in   DW      word to push
//  full       out  1       buffer holds DEPTH words; load ignored
//  level      out  AW+1    words held, including the one on data_out (0..DEPTH)
//  valid      out  1       data_out holds a word for the receiver
//  ready      in   1       receiver accepts data_out this edge
//  data_out   out  DW      head word, registered
//  ovf        out  1       sticky: load arrived while full
//  stall      out  1       sticky: valid held TIMEOUT cycles without ready
//  clr        in   1       clears ovf and stall
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): valid=0, data_out=0, level=0, full=0, ovf=0, stall=0.
//    Wait counter cleared; buffer contents discarded. Applies mid-transfer: valid drops on that
//    edge even if ready=1; that word is lost and not counted as transferred.
//  - Transfer = valid && ready at a posedge; head word popped on that edge.
//  - While valid && !ready: data_out and valid are held unchanged, every cycle.
//  - valid = (level != 0). data_out always equals the oldest held word (FWFT).
//  - Latency: load into an empty buffer at edge N -> valid=1, data_out=load_data after edge N.
//  - Back-to-back: with ready=1 continuously and a load every cycle, one transfer per cycle,
//    words in load order, no bubbles.
//  - Accept rule: load accepted iff !full before the edge. A pop on the same edge does NOT
//    make room for a load while full. Rejected load sets ovf; buffer is unchanged.
//  - Simultaneous load+transfer, not full: level unchanged; new word enqueued behind.
//    If level==1, data_out becomes load_data after the edge.
//  - level: +1 on accepted load only, -1 on transfer only, unchanged on both or neither.
//    full = (level == DEPTH).
//  - Pointers: AW-bit read/write pointers, wrap modulo DEPTH; level is tracked separately
//    (no pointer-compare ambiguity).
//  - Wait counter: +1 each cycle with valid && !ready, saturating at TIMEOUT.
//    Reset to 0 on a transfer or when valid=0. On reaching TIMEOUT (TIMEOUT>0), stall sets.
//  - clr=1 clears ovf and stall at the edge. If a set condition occurs on the same edge, the
//    set wins. clr does not touch the buffer or the wait counter.
//  - No combinational path from ready to valid or to data_out.
// TESTING
//  1 Reset: rst_n=0 for 2 cycles with load=1 -> valid=0, data_out=0, level=0, ovf=0 after release.
//  2 Stream: ready=1, load 0..7 on consecutive cycles -> receiver sees 0..7 on consecutive edges;
//    level<=1; full never set.
//  3 Hold: load 5, ready=0 for 6 cycles, then 1 -> data_out=5 and valid=1 steady 6 cycles;
//    one transfer; valid=0 next.
//  4 Full/ovf (DEPTH=4): ready=0, load 1,2,3,4,9 -> full=1, level=4, ovf=1.
//    Then ready=1 -> receiver gets 1,2,3,4 only.
//  5 Full+pop same edge: full, load=1 with ready=1 -> word rejected, ovf=1, level=3.
//  6 Stall: TIMEOUT=16, ready=0 with valid=1 -> stall=1 exactly after the 16th waiting edge.
//    clr -> stall=0. Reset mid-stream with ready=1 -> valid=0 next edge; no extra word accepted.

Source files
------------

// File: rtl/handshake_tx_if.sv
// Valid/ready word channel between the transmit buffer and a downstream receiver.
interface handshake_tx_if #(
    parameter int DW = 4
);
    logic          valid;
    logic          ready;
    logic [DW-1:0] data_out;

    modport master (output valid, output data_out, input ready);
    modport slave  (input valid, input data_out, output ready);
endinterface

// File: rtl/handshake_tx.sv
// Source end of a valid/ready link: a first-word-fall-through buffer that holds the head
// word steady until accepted, with sticky overflow and receiver-stall flags.
module handshake_tx #(
    parameter int DW      = 4,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     load,
    input  logic [DW-1:0]            load_data,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     ovf,
    output logic                     stall,
    input  logic                     clr,
    handshake_tx_if.master           hs
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [AW:0]   LVL_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   LVL_FULL = (AW+1)'(DEPTH);
    localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW:0]   level_q;
    logic [DW-1:0] data_q;
    logic [DW-1:0] data_nxt;
    logic [CW-1:0] wait_cnt;
    logic          ovf_q;
    logic          stall_q;
    logic          valid;
    logic          push;
    logic          pop;
    logic          waiting;
    logic          ovf_set;
    logic          stall_set;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        if (v >= CNT_MAX) return CNT_MAX;
        return v + CW'(1);
    endfunction

    assign valid       = (level_q != '0);
    assign full        = (level_q == LVL_FULL);
    assign level       = level_q;
    assign ovf         = ovf_q;
    assign stall       = stall_q;
    assign hs.valid    = valid;
    assign hs.data_out = data_q;

    // A pop never frees space for a load on the same edge, so push looks only at full.
    assign push      = load && !full;
    assign pop       = valid && hs.ready;
    assign waiting   = valid && !hs.ready;
    assign ovf_set   = load && full;
    assign stall_set = (TIMEOUT > 0) && waiting && (wait_cnt == CNT_LAST);

    // Head register: takes the incoming word when it becomes the head, else the next entry.
    always_comb begin
        data_nxt = data_q;
        if (push && ((level_q == '0) || (pop && (level_q == LVL_ONE)))) begin
            data_nxt = load_data;
        end else if (pop && (level_q > LVL_ONE)) begin
            data_nxt = mem[rd_ptr + AW'(1)];
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= load_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            level_q  <= '0;
            data_q   <= '0;
            wait_cnt <= '0;
            ovf_q    <= 1'b0;
            stall_q  <= 1'b0;
        end else begin
            data_q <= data_nxt;
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   level_q <= level_q + LVL_ONE;
                2'b01:   level_q <= level_q - LVL_ONE;
                default: level_q <= level_q;
            endcase
            wait_cnt <= waiting ? sat_inc(wait_cnt) : '0;
            if (ovf_set)      ovf_q <= 1'b1;
            else if (clr)     ovf_q <= 1'b0;
            if (stall_set)    stall_q <= 1'b1;
            else if (clr)     stall_q <= 1'b0;
        end
    end
endmodule
